// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture controller slice.
package adc_capture_pkg;

    localparam int DATA_W     = 16;
    localparam int CNT_W_DEF  = 24;
    localparam int DROP_W_DEF = 16;
    localparam int DECIM_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// FIFO write port between the capture controller (master) and the ADC sample FIFO (slave).
interface adc_capture_ctrl_if;

    logic [2*adc_capture_pkg::DATA_W-1:0] fifo_din;
    logic                                 fifo_wr_en;
    logic                                 fifo_prog_full;
    logic                                 fifo_busy;

    modport master (
        output fifo_din,
        output fifo_wr_en,
        input  fifo_prog_full,
        input  fifo_busy
    );

    modport slave (
        input  fifo_din,
        input  fifo_wr_en,
        output fifo_prog_full,
        output fifo_busy
    );

endinterface

// File: rtl/adc_capture_decim.sv
// Decimation phase counter: keeps one candidate sample out of every decim+1.
module adc_capture_decim
    import adc_capture_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               candidate,
    input  logic [DECIM_W-1:0] decim,
    output logic               keep
);

    logic [DECIM_W-1:0] phase_q;

    // Phase wraps after reaching decim, so phase 0 marks the kept candidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (clear) begin
            phase_q <= '0;
        end else if (candidate) begin
            if (phase_q >= decim) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + DECIM_W'(1);
            end
        end
    end

    assign keep = candidate && (phase_q == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: writes a programmed number of decimated sample words into the FIFO.
// Optional ramp test pattern on fifo_din when ADC_CAPTURE_TESTPAT_EN is defined.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   capture_len,
    input  logic [DECIM_W-1:0] decim,
    input  logic               adc_rdy,
    input  logic               adc_valid,
    input  logic [DATA_W-1:0]  adc_data_1,
    input  logic [DATA_W-1:0]  adc_data_2,
`ifdef ADC_CAPTURE_TESTPAT_EN
    input  logic               testpat,
`endif
    adc_capture_ctrl_if.master fifo,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_count,
    output logic [CNT_W-1:0]   wr_count
);

    cap_state_t state_q;
    cap_state_t state_d;

    logic [CNT_W-1:0]    len_q;
    logic [DECIM_W-1:0]  decim_q;
    logic [CNT_W-1:0]    wr_count_inc;
    logic [2*DATA_W-1:0] din_sel;

    logic start_acc;
    logic arm_go;
    logic rdy_lost;
    logic candidate;
    logic keep;
    logic do_write;
    logic do_drop;
    logic last_write;

    // Abort overrides every other event, including a start in the same cycle.
    assign start_acc  = (state_q == IDLE) && start && !abort;
    assign arm_go     = (state_q == ARMED) && !abort && adc_rdy && adc_valid && !fifo.fifo_busy;
    assign rdy_lost   = (state_q == CAPTURE) && !abort && !adc_rdy;
    assign candidate  = arm_go || ((state_q == CAPTURE) && !abort && adc_rdy && adc_valid);

    assign do_write     = keep && !fifo.fifo_prog_full && !fifo.fifo_busy;
    assign do_drop      = keep && !do_write;
    assign wr_count_inc = wr_count + CNT_W'(1);
    assign last_write   = do_write && (len_q != '0) && (wr_count_inc == len_q);

    assign busy = (state_q != IDLE);

    adc_capture_decim u_decim (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state_q == IDLE),
        .candidate (candidate),
        .decim     (decim_q),
        .keep      (keep)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (arm_go) begin
                    state_d = last_write ? IDLE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort || rdy_lost || last_write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [DATA_W-1:0] ramp_q;

    // Ramp advances on dropped samples too, so the host sees gaps where drops occurred.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp_q <= '0;
        end else if (start_acc) begin
            ramp_q <= '0;
        end else if (keep) begin
            ramp_q <= ramp_q + DATA_W'(1);
        end
    end

    assign din_sel = testpat ? {ramp_q, ~ramp_q} : {adc_data_1, adc_data_2};
`else
    assign din_sel = {adc_data_1, adc_data_2};
`endif

    // Capture settings and status are latched on the accepted start and held afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo.fifo_din   <= '0;
            fifo.fifo_wr_en <= 1'b0;
            len_q           <= '0;
            decim_q         <= '0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            drop_count      <= '0;
            wr_count        <= '0;
        end else begin
            fifo.fifo_wr_en <= do_write;
            if (do_write) begin
                fifo.fifo_din <= din_sel;
                wr_count      <= wr_count_inc;
            end
            if (start_acc) begin
                len_q      <= capture_len;
                decim_q    <= decim;
                done       <= 1'b0;
                overflow   <= 1'b0;
                drop_count <= '0;
                wr_count   <= '0;
            end else begin
                if (last_write) begin
                    done <= 1'b1;
                end
                if (do_drop || rdy_lost) begin
                    overflow <= 1'b1;
                end
                if (do_drop && !(&drop_count)) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: expected FIFO words queued at stimulus time, popped on fifo_wr_en.
module tb_adc_capture_ctrl;

    localparam int CNT_W  = 24;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  capture_len;
    logic [7:0]        decim;
    logic              adc_rdy;
    logic              adc_valid;
    logic [15:0]       adc_data_1;
    logic [15:0]       adc_data_2;
`ifdef ADC_CAPTURE_TESTPAT_EN
    logic              testpat;
`endif
    logic              busy;
    logic              done;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic [CNT_W-1:0]  wr_count;

    logic [15:0] s1;
    logic [15:0] s2;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    int          w0;

    adc_capture_ctrl_if fifo_bus ();

    adc_capture_ctrl #(
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .capture_len (capture_len),
        .decim       (decim),
        .adc_rdy     (adc_rdy),
        .adc_valid   (adc_valid),
        .adc_data_1  (adc_data_1),
        .adc_data_2  (adc_data_2),
`ifdef ADC_CAPTURE_TESTPAT_EN
        .testpat     (testpat),
`endif
        .fifo        (fifo_bus.master),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rdy, input logic pf,
                                 input logic [15:0] d1, input logic [15:0] d2);
        adc_valid               = valid;
        adc_rdy                 = rdy;
        fifo_bus.fifo_prog_full = pf;
        adc_data_1              = d1;
        adc_data_2              = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        end
    endtask

    task automatic startCapture(input logic [CNT_W-1:0] len, input logic [7:0] dec);
        capture_len = len;
        decim       = dec;
        start       = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("wr_count_cleared", wr_count, '0);
        checkOutput("drop_count_cleared", drop_count, '0);
        checkOutput("done_cleared", done, 1'b0);
    endtask

    // Scoreboard side: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && fifo_bus.fifo_wr_en === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("wr_while_sb_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                checkOutput("fifo_din", fifo_bus.fifo_din, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n                 = 1'b1;
        start                   = 1'b0;
        abort                   = 1'b0;
        capture_len             = '0;
        decim                   = '0;
        adc_rdy                 = 1'b0;
        adc_valid               = 1'b0;
        adc_data_1              = '0;
        adc_data_2              = '0;
        fifo_bus.fifo_prog_full = 1'b0;
        fifo_bus.fifo_busy      = 1'b0;
`ifdef ADC_CAPTURE_TESTPAT_EN
        testpat                 = 1'b0;
`endif
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_fifo_din", fifo_bus.fifo_din, '0);
        checkOutput("rst_wr_en", fifo_bus.fifo_wr_en, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_drop_count", drop_count, '0);
        checkOutput("rst_wr_count", wr_count, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] len=8 decim=0 steady valid");
        w0 = writes_seen;
        startCapture(24'd8, 8'd0);
        for (int i = 0; i < 10; i++) begin
            s1 = 16'(16'h1100 + i);
            s2 = 16'($urandom);
            if (i < 8) exp_q.push_back({s1, s2});
            applyStimulus(1'b1, 1'b1, 1'b0, s1, s2);
        end
        idleCycles(2);
        checkOutput("t1_done", done, 1'b1);
        checkOutput("t1_wr_count", wr_count, 24'd8);
        checkOutput("t1_overflow", overflow, 1'b0);
        checkOutput("t1_busy", busy, 1'b0);
        checkOutput("t1_writes", 64'(writes_seen - w0), 64'd8);

        $display("[TB] len=4 decim=2");
        w0 = writes_seen;
        startCapture(24'd4, 8'd2);
        decim       = 8'd0;
        capture_len = 24'd1;
        for (int i = 0; i < 12; i++) begin
            s1 = 16'(16'h2200 + i);
            s2 = 16'($urandom);
            if (i % 3 == 0 && i <= 9) exp_q.push_back({s1, s2});
            applyStimulus(1'b1, 1'b1, 1'b0, s1, s2);
        end
        idleCycles(2);
        checkOutput("t2_done", done, 1'b1);
        checkOutput("t2_wr_count", wr_count, 24'd4);
        checkOutput("t2_writes", 64'(writes_seen - w0), 64'd4);

        $display("[TB] len=10 prog_full on samples 3-5");
        w0 = writes_seen;
        startCapture(24'd10, 8'd0);
        for (int i = 0; i < 15; i++) begin
            s1 = 16'(16'h3300 + i);
            s2 = 16'($urandom);
            if ((i < 3) || (i >= 6 && i <= 12)) exp_q.push_back({s1, s2});
            applyStimulus(1'b1, 1'b1, (i >= 3 && i <= 5), s1, s2);
        end
        idleCycles(2);
        checkOutput("t3_drop_count", drop_count, 16'd3);
        checkOutput("t3_overflow", overflow, 1'b1);
        checkOutput("t3_done", done, 1'b1);
        checkOutput("t3_wr_count", wr_count, 24'd10);
        checkOutput("t3_writes", 64'(writes_seen - w0), 64'd10);

        $display("[TB] continuous, abort after 20 writes");
        startCapture(24'd0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            s1 = 16'(16'h4400 + i);
            s2 = 16'($urandom);
            exp_q.push_back({s1, s2});
            if (i == 10) begin
                start       = 1'b1;
                capture_len = 24'd3;
            end
            applyStimulus(1'b1, 1'b1, 1'b0, s1, s2);
            start = 1'b0;
        end
        abort = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        abort = 1'b0;
        checkOutput("t4_busy", busy, 1'b0);
        checkOutput("t4_done", done, 1'b0);
        checkOutput("t4_wr_count", wr_count, 24'd20);
        idleCycles(2);
        checkOutput("t4_wr_count_held", wr_count, 24'd20);
        startCapture(24'd7, 8'd0);
        abort = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        abort = 1'b0;
        checkOutput("t4_abort_armed", busy, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("t4_start_abort_same", busy, 1'b0);

        $display("[TB] armed wait for adc_rdy, then rdy loss");
        startCapture(24'd0, 8'd0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h5555, 16'hAAAA);
        end
        checkOutput("t5_armed_busy", busy, 1'b1);
        checkOutput("t5_armed_wr_count", wr_count, '0);
        for (int i = 0; i < 6; i++) begin
            s1 = 16'(16'h5500 + i);
            s2 = 16'($urandom);
            exp_q.push_back({s1, s2});
            applyStimulus(1'b1, 1'b1, 1'b0, s1, s2);
            if (i == 0) checkOutput("t5_first_wr_latency", fifo_bus.fifo_wr_en, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_overflow", overflow, 1'b1);
        checkOutput("t5_done", done, 1'b0);
        checkOutput("t5_wr_count", wr_count, 24'd6);
        idleCycles(2);

`ifdef ADC_CAPTURE_TESTPAT_EN
        $display("[TB] test pattern len=5");
        testpat = 1'b1;
        startCapture(24'd5, 8'd0);
        for (int i = 0; i < 7; i++) begin
            s1 = 16'(i);
            if (i < 5) exp_q.push_back({s1, ~s1});
            applyStimulus(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
        end
        idleCycles(2);
        checkOutput("t6_done", done, 1'b1);
        checkOutput("t6_wr_count", wr_count, 24'd5);
`endif

        $display("[TB] reset mid-capture");
        startCapture(24'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            s1 = 16'(16'h7700 + i);
            s2 = 16'($urandom);
            exp_q.push_back({s1, s2});
            applyStimulus(1'b1, 1'b1, 1'b0, s1, s2);
        end
        adc_data_1 = 16'hCAFE;
        adc_data_2 = 16'hF00D;
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t7_fifo_din", fifo_bus.fifo_din, '0);
        checkOutput("t7_wr_en", fifo_bus.fifo_wr_en, 1'b0);
        checkOutput("t7_busy", busy, 1'b0);
        checkOutput("t7_done", done, 1'b0);
        checkOutput("t7_overflow", overflow, 1'b0);
        checkOutput("t7_drop_count", drop_count, '0);
        checkOutput("t7_wr_count", wr_count, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        idleCycles(3);
        checkOutput("t7_busy_after", busy, 1'b0);
`ifdef ADC_CAPTURE_TESTPAT_EN
        testpat = 1'b0;
`endif

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture controller between the SYZYGY ADC receiver outputs and the ADC sample FIFO write port, in the ADC data-clock domain. On a start pulse it writes a programmed number of two-channel sample words into the FIFO, with optional sample decimation. It honours FIFO back-pressure and counts dropped samples. Status is exported for the host wire/trigger endpoints.

## Interface
Parameters:
- CNT_W, 24, width of the capture-length and written-sample counters
- DROP_W, 16, width of the dropped-sample counter (saturating)

Ports:
- clk  in  1  ADC data clock; the single clock of the block
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle capture start pulse, already synchronised to clk
- abort  in  1  one-cycle pulse; ends the capture immediately
- capture_len  in  CNT_W  number of words to write; 0 means continuous
- decim  in  8  keep 1 of every decim+1 valid samples; 0 = keep all
- adc_rdy  in  1  receiver ready (MMCM/SERDES up)
- adc_valid  in  1  sample valid (frame aligned) this cycle
- adc_data_1  in  16  channel 1 sample
- adc_data_2  in  16  channel 2 sample
- fifo_prog_full  in  1  FIFO back-pressure
- fifo_busy  in  1  FIFO reset sequence in progress
- fifo_din  out  32  {adc_data_1, adc_data_2}
- fifo_wr_en  out  1  write strobe, one word per cycle
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  sticky; set on normal completion
- overflow  out  1  sticky; set when a kept sample was dropped
- drop_count  out  DROP_W  dropped kept samples, saturates at all-ones
- wr_count  out  CNT_W  words written in current/last capture

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: start → ARMED. Also clears done, overflow, drop_count, wr_count and the decimation phase.
- ARMED: wait until adc_rdy & adc_valid & ~fifo_busy. The first such cycle moves to CAPTURE, and that sample is the first candidate.
- CAPTURE, candidate cycle: adc_valid & adc_rdy.
  - Decimation phase counter runs from 0 to decim on each candidate cycle.
  - A candidate is "kept" when the phase is 0.
- Kept sample with fifo_prog_full=0 and fifo_busy=0:
  - registered into fifo_din, fifo_wr_en pulses;
  - wr_count increments.
- Kept sample with fifo_prog_full=1 or fifo_busy=1:
  - no write;
  - drop_count increments (saturating);
  - overflow set.
- capture_len≠0: when wr_count reaches capture_len after a write, go to IDLE and set done.
- capture_len=0: capture continues until abort.
- abort in ARMED or CAPTURE → IDLE; done is not set. Counters hold for readback.
- adc_rdy falling during CAPTURE → IDLE; overflow set.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- capture_len and decim are sampled into internal registers on the accepted start. Later changes do not affect the running capture.
- wr_count wraps in continuous mode. drop_count never wraps.

## Timing
- Reset values: fifo_din=0, fifo_wr_en=0, busy=0, done=0, overflow=0, drop_count=0, wr_count=0, state IDLE.
- Latency: adc_data_* to fifo_din/fifo_wr_en is 1 clk, registered.
- fifo_wr_en is asserted only while fifo_prog_full and fifo_busy were both low in the sampling cycle. The FIFO prog_full threshold covers the 1-cycle slack.
- busy rises 1 clk after start.
- done and the final wr_count update land in the same cycle as the last fifo_wr_en. busy falls that same cycle.
- Back-to-back writes at full clk rate are allowed when decim=0.
- reset_n asserted mid-capture: all outputs return to reset values asynchronously; a write in flight is lost.

## Configuration
- ADC_CAPTURE_TESTPAT_EN defined:
  - adds input testpat (1 bit, static);
  - when testpat=1, fifo_din = {ramp[15:0], ~ramp[15:0]};
  - ramp is a 16-bit counter, cleared on accepted start, incremented per kept sample including dropped ones.
  - Gaps in the ramp reveal drops on the host.
- Not defined: no testpat port, no ramp logic; fifo_din is always ADC data.

## Structure
- Shared package adc_capture_pkg holds:
  - state enum (IDLE/ARMED/CAPTURE);
  - DATA_W=16;
  - default CNT_W/DROP_W constants.
- Sub-module adc_capture_decim: decimation phase counter plus keep strobe, inputs candidate/decim/clear.

## Test plan
- capture_len=8, decim=0, steady valid, no back-pressure → exactly 8 fifo_wr_en, data matches input delayed 1 clk, done=1, wr_count=8, overflow=0.
- capture_len=4, decim=2, valid every cycle → writes on input samples 0,3,6,9; done after the 4th write.
- capture_len=10, prog_full high for samples 3–5 → 10 words written over a longer span, drop_count=3, overflow=1, done=1.
- capture_len=0, abort after 20 writes → busy=0, done=0, wr_count=20; a following start clears counters.
- Start with adc_rdy=0, raise adc_rdy after 50 clks → state holds ARMED, first write 1 clk after the first rdy&valid; adc_rdy dropped mid-capture → IDLE, overflow=1.
- ADC_CAPTURE_TESTPAT_EN, testpat=1, capture_len=5 → fifo_din = {0000,FFFF}, {0001,FFFE} … {0004,FFFB}; reset_n pulse mid-run zeroes all outputs.
